overlay_fetch: RTL and testbench
================================

# overlay_fetch

Parametrised overlay pixel streamer for the vector display path. It prefetches packed overlay words from SDRAM through a single-outstanding request/acknowledge port into a small word FIFO, unpacks them into pixels, and emits one pixel per active-display pixel enable. It restarts at every vsync rising edge, with a per-orientation base address, and flags underruns. Successor to the fixed 2-word, 16-bit overlay fetch in the top level: width, depth, pixel size and frame size are all generic.

## Interface
- `WORD_W`, 32, memory data width; must be a multiple of `PIX_W`.
- `PIX_W`, 16, pixel width (ABGR 4:4:4:4 at 16).
- `FIFO_DEPTH`, 8, FIFO depth in words; power of two, ≥2.
- `ADDR_W`, 25, memory word-address width.
- `FRAME_WORDS`, 194400, words per frame (540×720 pixels at 2 pixels/word).
- `BASE_H`, 0, word base address for horizontal orientation.
- `BASE_V`, 'h100000, word base address for vertical orientation.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  overlay loaded and not downloading; 0 forces IDLE.
- `orient`  in  1  0 selects `BASE_H`, 1 selects `BASE_V`; sampled at frame restart.
- `vs`  in  1  vertical sync; a rising edge starts a frame.
- `de`  in  1  active display.
- `ce_pix`  in  1  pixel clock enable.
- `mem_req`  out  1  single-cycle read request pulse.
- `mem_addr`  out  ADDR_W  word address, valid while `mem_req`=1.
- `mem_ack`  in  1  single-cycle pulse: `mem_data` valid.
- `mem_data`  in  WORD_W  read data.
- `pix`  out  PIX_W  current overlay pixel.
- `underrun`  out  1  sticky per frame: a pixel was demanded while the FIFO was empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  words held.

## Operation
- States: IDLE, DRAIN, FETCH, DONE.
- Any state with `enable`=0 goes to IDLE. IDLE clears the FIFO, `pix`, `underrun` and the sub-pixel index.
- The vs rising edge (registered `vs` 0→1) is detected every clock and applies in IDLE (only if `enable`), FETCH and DONE. On the edge:
  - clear the FIFO, sub-pixel index and `underrun`;
  - load `addr` ← base(`orient`) and `remaining` ← `FRAME_WORDS`;
  - go to DRAIN if a request is outstanding, otherwise FETCH.
- DRAIN: wait for `mem_ack`, discard its data, then go to FETCH.
- FETCH issues `mem_req` with `mem_addr`=`addr` when no request is outstanding and `fifo_level` < `FIFO_DEPTH`. After issuing: `addr`+1, `remaining`−1. When `remaining` reaches 0, go to DONE.
- DONE issues no requests; it still accepts the final ack.
- `mem_ack` outside DRAIN writes `mem_data` into the FIFO. Overflow cannot occur because of the issue rule.
- Pixel demand = `ce_pix` & `de` & state≠IDLE.
  - On demand with the FIFO non-empty: `pix` ← head word slice [idx*PIX_W +: PIX_W], least significant slice first. idx increments; on idx = WORD_W/PIX_W−1 the word pops and idx returns to 0.
  - On demand with the FIFO empty: set `underrun`; `pix` behaviour per Configuration.
- `pix` holds its value outside demand cycles; downstream masks blanking.
- A vs edge and a demand in the same cycle: the vs edge wins and the demand is ignored.
- An ack and a pop in the same cycle: both apply and the level is unchanged.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `pix`=0, `underrun`=0, `fifo_level`=0, state IDLE.
- `mem_req` is registered and lasts exactly one cycle. The first request follows one clock after the vs edge is registered, i.e. 2 clocks after `vs` rises.
- `pix` updates 1 clock after the demand cycle.
- Ack latency is unbounded; at most one request is ever outstanding.
- `remaining` is $clog2(FRAME_WORDS+1) bits wide. `addr` wraps modulo 2^ADDR_W.
- Reset mid-request drops the outstanding request. A late `mem_ack` arriving after reset is ignored because the block is in IDLE.

## Configuration
- `OVL_UNDERRUN_HOLD_EN` defined: on underrun `pix` holds its last value.
- Not defined: on underrun `pix` ← 0, i.e. a transparent pixel.
- `underrun` flagging is identical in both builds.

## Test plan
- Basic stream: `FRAME_WORDS`=4, memory returns 'hBBBBAAAA, 'hDDDDCCCC, …; enable, vs edge, ack after 3 clocks, sustained demand → `pix` = AAAA, BBBB, CCCC, DDDD, …; exactly 4 requests at addresses 0..3, then DONE.
- Prefetch limit: no demand, `FIFO_DEPTH`=8 → exactly 8 requests issued, `fifo_level`=8; one word popped → exactly one further request.
- Orientation: `orient`=1 at the vs edge → first `mem_addr`='h100000. Toggling `orient` mid-frame does not change addresses until the next vs edge.
- Vs edge while a request is outstanding: vs rises with the ack pending → the data (e.g. 'hDEADBEEF) is discarded, the next request goes to base+0, and the FIFO starts empty.
- Underrun: demand with the ack delayed 20 clocks → `underrun`=1; `pix`=0 without the macro, last pixel with `OVL_UNDERRUN_HOLD_EN`; `underrun` clears at the next vs edge.
- Async reset asserted mid-FETCH without a clock edge → all outputs reach their reset values immediately, and a late `mem_ack` is ignored.

Source files
------------

// File: rtl/overlay_fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  overlay_fetch_if : single-outstanding SDRAM read port for overlay_fetch
//  Revision: 1.0
// ============================================================================
interface overlay_fetch_if #(
  parameter int ADDR_W = 25,
  parameter int WORD_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface
`default_nettype wire

// File: rtl/overlay_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  overlay_fetch : prefetching overlay pixel streamer (vsync-restarted frames)
//  Option macro OVL_UNDERRUN_HOLD_EN: hold last pixel on underrun (else 0).
//  Revision: 1.0
// ============================================================================
module overlay_fetch #(
  parameter int                WORD_W      = 32,
  parameter int                PIX_W       = 16,
  parameter int                FIFO_DEPTH  = 8,
  parameter int                ADDR_W      = 25,
  parameter int                FRAME_WORDS = 194400,
  parameter logic [ADDR_W-1:0] BASE_H      = '0,
  parameter logic [ADDR_W-1:0] BASE_V      = ADDR_W'(32'h0010_0000)
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic                              enable_i,
  input  logic                              orient_i,
  input  logic                              vs_i,
  input  logic                              de_i,
  input  logic                              ce_pix_i,
  overlay_fetch_if.master                   mem,
  output logic [PIX_W-1:0]                  pix_o,
  output logic                              underrun_o,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o
);
  localparam int NPIX  = WORD_W / PIX_W;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REM_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FETCH, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     vs_q, out_q, out_d, req_q, req_d, urun_q, urun_d;
  logic [ADDR_W-1:0]        maddr_q, maddr_d, addr_q, addr_d;
  logic [REM_W-1:0]         rem_q, rem_d;
  logic [LVL_W-1:0]         wptr_q, wptr_d, rptr_q, rptr_d, level;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [PIX_W-1:0]         pix_q, pix_d;
  logic [WORD_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [NPIX-1:0][PIX_W-1:0] head_pix;
  logic                     vs_rise, restart, demand, issue, push, pop, empty;

  assign level    = wptr_q - rptr_q;
  assign empty    = (level == '0);
  assign head_pix = fifo_mem[rptr_q[PTR_W-1:0]];
  assign vs_rise  = vs_i & ~vs_q;
  // A vsync edge is ignored while draining; it wins over a same-cycle demand.
  assign restart  = enable_i & vs_rise & (state_q != S_DRAIN);
  assign demand   = ce_pix_i & de_i & (state_q != S_IDLE) & ~restart;
  assign issue    = enable_i & (state_q == S_FETCH) & ~restart & ~out_q
                  & (level < LVL_W'(FIFO_DEPTH)) & (rem_q != '0);
  assign push     = mem.mem_ack & ((state_q == S_FETCH) | (state_q == S_DONE)) & ~restart;
  assign pop      = demand & ~empty & (idx_q == IDX_W'(NPIX - 1));

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    req_d   = issue;
    maddr_d = maddr_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    urun_d  = urun_q;

    if (issue) begin
      out_d   = 1'b1;
      maddr_d = addr_q;
      addr_d  = addr_q + ADDR_W'(1);
      rem_d   = rem_q - REM_W'(1);
    end else if (mem.mem_ack) begin
      out_d   = 1'b0;
    end

    if (push) wptr_d = wptr_q + LVL_W'(1);

    if (demand) begin
      if (!empty) begin
        pix_d = head_pix[idx_q];
        if (pop) begin
          idx_d  = '0;
          rptr_d = rptr_q + LVL_W'(1);
        end else begin
          idx_d  = idx_q + IDX_W'(1);
        end
      end else begin
        urun_d = 1'b1;
`ifdef OVL_UNDERRUN_HOLD_EN
        pix_d  = pix_q;
`else
        pix_d  = '0;
`endif
      end
    end

    case (state_q)
      S_DRAIN: if (mem.mem_ack) state_d = S_FETCH;
      S_FETCH: if (issue && (rem_q == REM_W'(1))) state_d = S_DONE;
      default: ;
    endcase

    // An ack landing on the restart cycle retires the old request itself.
    if (restart) begin
      state_d = (out_q & ~mem.mem_ack) ? S_DRAIN : S_FETCH;
      addr_d  = orient_i ? BASE_V : BASE_H;
      rem_d   = REM_W'(FRAME_WORDS);
      wptr_d  = '0;
      rptr_d  = '0;
      idx_d   = '0;
      urun_d  = 1'b0;
    end

    if (state_q == S_IDLE) begin
      wptr_d = '0;
      rptr_d = '0;
      idx_d  = '0;
      pix_d  = '0;
      urun_d = 1'b0;
    end

    if (!enable_i) state_d = S_IDLE;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b0;
      out_q   <= 1'b0;
      req_q   <= 1'b0;
      maddr_q <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_i;
      out_q   <= out_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      urun_q  <= urun_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) fifo_mem[wptr_q[PTR_W-1:0]] <= mem.mem_data;
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_addr  = maddr_q;
  assign pix_o         = pix_q;
  assign underrun_o    = urun_q;
  assign fifo_level_o  = level;
endmodule
`default_nettype wire

// File: tb/tb_overlay_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_overlay_fetch : directed self-checking bench for overlay_fetch
//  Revision: 1.0
// ============================================================================
module tb_overlay_fetch;
  localparam int WORD_W = 32, PIX_W = 16, FIFO_DEPTH = 8, ADDR_W = 25, FRAME_WORDS = 12;
  localparam logic [ADDR_W-1:0] BASE_V = 25'h100000;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, orient = 1'b0, vs = 1'b0, de = 1'b0, ce_pix = 1'b0;
  logic [PIX_W-1:0] pix;
  logic             underrun;
  logic [3:0]       level;

  int nvec = 0, nerr = 0;
  int nreq = 0, ack_delay = 3, cnt = 0, addr_err = 0, snap = 0;
  bit pending = 0, stall = 0, ovr_en = 0, ok;
  logic [31:0]       ovr_data = '0;
  logic [ADDR_W-1:0] paddr = '0, exp_next = '0;

  overlay_fetch_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  overlay_fetch #(
    .WORD_W(WORD_W), .PIX_W(PIX_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W),
    .FRAME_WORDS(FRAME_WORDS), .BASE_H('0), .BASE_V(BASE_V)
  ) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .orient_i(orient), .vs_i(vs),
    .de_i(de), .ce_pix_i(ce_pix), .mem(bus.master), .pix_o(pix),
    .underrun_o(underrun), .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  // Word at address a holds pixels {lo+1, lo}; lo tags orientation in its top nibble.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [15:0] lo;
    lo = {(a[20] ? 4'hC : 4'hA), a[10:0], 1'b0};
    return {lo | 16'h0001, lo};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic demand_chk(input int n, input logic [15:0] first, input string tag);
    de = 1'b1;
    for (int j = 0; j < n; j++) begin
      tick(1);
      check_vec($sformatf("%s[%0d]", tag, j), {16'h0, pix}, {16'h0, first + 16'(j)});
    end
    de = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.mem_req === 1'b1) begin ok = 1; break; end
    end
    check_vec(tag, {31'h0, ok}, 32'h1);
  endtask

  // Memory model: samples the request on the falling edge, answers after ack_delay.
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        nreq++;
        if (bus.mem_addr !== exp_next) addr_err++;
        exp_next = bus.mem_addr + 1'b1;
        pending  = 1;
        cnt      = ack_delay;
        paddr    = bus.mem_addr;
      end else if (pending && !stall) begin
        if (cnt <= 1) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = ovr_en ? ovr_data : mem_word(paddr);
          ovr_en  = 0;
          pending = 0;
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    ce_pix = 1'b1;
    tick(2);
    check_vec("rst_req",   {31'h0, bus.mem_req}, 32'h0);
    check_vec("rst_addr",  {7'h0, bus.mem_addr}, 32'h0);
    check_vec("rst_pix",   {16'h0, pix}, 32'h0);
    check_vec("rst_urun",  {31'h0, underrun}, 32'h0);
    check_vec("rst_level", {28'h0, level}, 32'h0);
    rst = 1'b0; enable = 1'b1;
    tick(2);

    // Horizontal frame: latency, prefetch limit, streaming order, end of frame.
    exp_next = '0;
    vs = 1'b1;
    tick(1);
    check_vec("req_early", {31'h0, bus.mem_req}, 32'h0);
    tick(1);
    check_vec("req_first", {31'h0, bus.mem_req}, 32'h1);
    check_vec("addr_first", {7'h0, bus.mem_addr}, 32'h0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin tick(1); if (level == 4'd8) begin ok = 1; break; end end
    check_vec("tmo_fill", {31'h0, ok}, 32'h1);
    tick(20);
    check_vec("pf_nreq", nreq, 32'd8);
    check_vec("pf_level", {28'h0, level}, 32'd8);
    demand_chk(2, 16'hA000, "pix_w0");
    tick(20);
    check_vec("pf_nreq_pop", nreq, 32'd9);
    check_vec("pf_level_pop", {28'h0, level}, 32'd8);
    demand_chk(14, 16'hA002, "pix_w1");
    ok = 0;
    for (int i = 0; i < 200; i++) begin tick(1); if (nreq == 12 && !pending) begin ok = 1; break; end end
    check_vec("tmo_frame", {31'h0, ok}, 32'h1);
    tick(3);
    check_vec("tail_level", {28'h0, level}, 32'd4);
    demand_chk(8, 16'hA010, "pix_w8");
    check_vec("end_level", {28'h0, level}, 32'd0);
    check_vec("end_urun", {31'h0, underrun}, 32'h0);
    tick(10);
    check_vec("done_nreq", nreq, 32'd12);
    de = 1'b1;
    tick(1);
    de = 1'b0;
    check_vec("urun_set", {31'h0, underrun}, 32'h1);
`ifdef OVL_UNDERRUN_HOLD_EN
    check_vec("urun_pix", {16'h0, pix}, 32'h0000_A017);
`else
    check_vec("urun_pix", {16'h0, pix}, 32'h0);
`endif

    // Vertical frame; orientation toggled mid-frame must not matter.
    vs = 1'b0; orient = 1'b1; exp_next = BASE_V;
    tick(2);
    vs = 1'b1;
    tick(1);
    check_vec("urun_clr", {31'h0, underrun}, 32'h0);
    tick(1);
    check_vec("v_req", {31'h0, bus.mem_req}, 32'h1);
    check_vec("v_addr0", {7'h0, bus.mem_addr}, 32'h0010_0000);
    orient = 1'b0;
    wait_req("tmo_v1");
    check_vec("v_addr1", {7'h0, bus.mem_addr}, 32'h0010_0001);
    demand_chk(1, 16'hC000, "pix_v");

    // Asynchronous reset between clock edges with a request in flight.
    wait_req("tmo_v2");
    stall = 1;
    #2 rst = 1'b1;
    #1;
    check_vec("arst_req",   {31'h0, bus.mem_req}, 32'h0);
    check_vec("arst_addr",  {7'h0, bus.mem_addr}, 32'h0);
    check_vec("arst_pix",   {16'h0, pix}, 32'h0);
    check_vec("arst_level", {28'h0, level}, 32'h0);
    vs = 1'b0;
    tick(3);
    rst = 1'b0;
    snap = nreq;
    stall = 0;
    tick(10);
    check_vec("late_ack_level", {28'h0, level}, 32'h0);
    check_vec("late_ack_nreq", nreq, snap);

    // Restart with the ack still pending: its data must be dropped.
    exp_next = '0; stall = 1;
    vs = 1'b1;
    tick(2);
    check_vec("d_req", {31'h0, bus.mem_req}, 32'h1);
    vs = 1'b0;
    tick(1);
    vs = 1'b1;
    tick(1);
    ovr_data = 32'hDEAD_BEEF; ovr_en = 1; exp_next = '0; stall = 0;
    wait_req("tmo_drain");
    check_vec("d_addr", {7'h0, bus.mem_addr}, 32'h0);
    check_vec("d_level", {28'h0, level}, 32'h0);
    ok = 0;
    for (int i = 0; i < 50; i++) begin tick(1); if (level == 4'd1) begin ok = 1; break; end end
    check_vec("tmo_d_fill", {31'h0, ok}, 32'h1);
    demand_chk(1, 16'hA000, "pix_d");
    check_vec("addr_seq", addr_err, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
